// File: rtl/lab4_sys_refill_arb_pkg.sv
// Shared types and helpers for the lab4 refill arbiter: memory message structs,
// FSM state enum and the opaque-field requester-ID slice helpers.
package lab4_sys_refill_arb_pkg;

    localparam int unsigned OPQ_W  = 8;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned TEST_W = 2;

    localparam logic [TYPE_W-1:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [TYPE_W-1:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [TYPE_W-1:0] MEM_TYPE_INIT  = 3'd2;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [OPQ_W-1:0]  opaque;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [OPQ_W-1:0]  opaque;
        logic [TEST_W-1:0] test;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } mem_resp_16B_t;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // Number of opaque MSBs used to carry the requester ID.
    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    // Requester ID held in the top idw bits of the opaque field, right-aligned.
    function automatic logic [OPQ_W-1:0] opq_get_id(input logic [OPQ_W-1:0] opq,
                                                     input int unsigned      idw);
        return opq >> (OPQ_W - idw);
    endfunction

    // Replace the top idw bits of the opaque field with the right-aligned id.
    function automatic logic [OPQ_W-1:0] opq_set_id(input logic [OPQ_W-1:0] opq,
                                                     input logic [OPQ_W-1:0] id,
                                                     input int unsigned      idw);
        logic [OPQ_W-1:0] keep;
        keep = {OPQ_W{1'b1}} >> idw;
        return (opq & keep) | OPQ_W'(id << (OPQ_W - idw));
    endfunction

endpackage

// File: rtl/lab4_sys_refill_arbiter_if.sv
// Bus bundle of the refill arbiter: NREQ cache-side request/response channels
// plus the single memory-side channel. The arbiter uses the slave modport.
interface lab4_sys_refill_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    import lab4_sys_refill_arb_pkg::*;

    mem_req_16B_t    in_req_msg  [NREQ];
    logic [NREQ-1:0] in_req_val;
    logic [NREQ-1:0] in_req_rdy;
    mem_resp_16B_t   in_resp_msg [NREQ];
    logic [NREQ-1:0] in_resp_val;
    logic [NREQ-1:0] in_resp_rdy;

    mem_req_16B_t    out_req_msg;
    logic            out_req_val;
    logic            out_req_rdy;
    mem_resp_16B_t   out_resp_msg;
    logic            out_resp_val;
    logic            out_resp_rdy;

    modport slave (
        input  in_req_msg, in_req_val, in_resp_rdy,
               out_req_rdy, out_resp_msg, out_resp_val,
        output in_req_rdy, in_resp_msg, in_resp_val,
               out_req_msg, out_req_val, out_resp_rdy
    );

    modport master (
        output in_req_msg, in_req_val, in_resp_rdy,
               out_req_rdy, out_resp_msg, out_resp_val,
        input  in_req_rdy, in_resp_msg, in_resp_val,
               out_req_msg, out_req_val, out_resp_rdy
    );

endinterface

// File: rtl/lab4_sys_rr_arbiter.sv
// Round-robin pick: first eligible requester at or after rr_ptr (wrapping),
// plus the pointer value to load once the granted request actually fires.
module lab4_sys_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   rr_ptr,
    input  logic            fire,
    input  logic [PW-1:0]   fire_idx,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any,
    output logic [PW-1:0]   ptr_next
);

    int unsigned idx;
    int unsigned nxt;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        nxt       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && eligible[PW'(idx)]) begin
                any               = 1'b1;
                grant[PW'(idx)]   = 1'b1;
                grant_idx         = PW'(idx);
            end
        end
        nxt = 32'(fire_idx) + 1;
        if (nxt >= NREQ) nxt = 0;
        ptr_next = fire ? PW'(nxt) : rr_ptr;
    end

endmodule

// File: rtl/lab4_sys_refill_arbiter.sv
// Shares one 16B memory port among NREQ refill ports; requester ID rides in the
// opaque MSBs. Define LAB4_SYS_REFILL_ARB_OUTBUF_EN for a registered out_req buffer.
module lab4_sys_refill_arbiter
    import lab4_sys_refill_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    lab4_sys_refill_arbiter_if.slave    bus,
    output logic                        route_err
);

    localparam int unsigned IDW = id_width(NREQ);

    arb_state_e         state;
    arb_state_e         state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     ptr_next;
    logic [IDW-1:0]     arb_idx;
    logic [IDW-1:0]     win_idx;
    logic [NREQ-1:0]    arb_grant;
    logic [NREQ-1:0]    win_onehot;
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    outstanding;
    logic [NREQ-1:0]    set_os;
    logic [NREQ-1:0]    clr_os;
    logic [OPQ_W-1:0]   saved_opq [NREQ];
    logic               arb_any;
    logic               accept;
    mem_req_16B_t       win_msg;

    assign eligible = bus.in_req_val & ~outstanding;

    lab4_sys_rr_arbiter #(.NREQ(NREQ), .PW(IDW)) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .fire      (accept),
        .fire_idx  (win_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any),
        .ptr_next  (ptr_next)
    );

    // Winner's message with its ID stamped into the opaque MSBs.
    always_comb begin
        win_msg        = bus.in_req_msg[win_idx];
        win_msg.opaque = opq_set_id(win_msg.opaque, OPQ_W'(win_idx), IDW);
    end

`ifdef LAB4_SYS_REFILL_ARB_OUTBUF_EN
    mem_req_16B_t buf_msg;
    logic         buf_val;

    // The buffer holds the message stable, so the FSM never leaves IDLE.
    always_comb begin
        state_next = IDLE;
        win_idx    = arb_idx;
        win_onehot = arb_grant;
        accept     = arb_any & (~buf_val | bus.out_req_rdy) & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_val <= 1'b0;
            buf_msg <= '0;
        end else if (accept) begin
            buf_val <= 1'b1;
            buf_msg <= win_msg;
        end else if (bus.out_req_rdy) begin
            buf_val <= 1'b0;
        end
    end

    assign bus.out_req_val = buf_val & ~reset;
    assign bus.out_req_msg = buf_msg;
`else
    logic [IDW-1:0] grant_q;
    logic           req_valid;

    // While LOCKED only the stalled winner is presented until memory takes it.
    always_comb begin
        state_next = state;
        win_idx    = arb_idx;
        win_onehot = arb_grant;
        req_valid  = arb_any;
        if (state == LOCKED) begin
            win_idx             = grant_q;
            win_onehot          = '0;
            win_onehot[grant_q] = 1'b1;
            req_valid           = bus.in_req_val[grant_q];
        end
        accept = req_valid & bus.out_req_rdy & ~reset;
        case (state)
            IDLE:    if (req_valid && !bus.out_req_rdy) state_next = LOCKED;
            LOCKED:  if (accept || !req_valid)          state_next = IDLE;
            default:                                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                                    grant_q <= '0;
        else if (state == IDLE && state_next == LOCKED) grant_q <= win_idx;
    end

    assign bus.out_req_val = req_valid & ~reset;
    assign bus.out_req_msg = win_msg;
`endif

    always_comb begin
        set_os = '0;
        if (accept) set_os = win_onehot;
    end

    assign bus.in_req_rdy = set_os;

    // Response demux: route by ID only when that requester really has one in flight.
    logic [OPQ_W-1:0] resp_id;
    logic [NREQ-1:0]  resp_hit;
    logic             resp_rdy_sel;
    logic             id_ok;
    logic             resp_fire;
    mem_resp_16B_t    resp_msg [NREQ];

    always_comb begin
        resp_id      = opq_get_id(bus.out_resp_msg.opaque, IDW);
        resp_hit     = '0;
        resp_rdy_sel = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            resp_msg[i]        = bus.out_resp_msg;
            resp_msg[i].opaque = opq_set_id(bus.out_resp_msg.opaque, saved_opq[i], IDW);
            if (resp_id == OPQ_W'(i) && outstanding[i]) begin
                resp_hit[i]  = 1'b1;
                resp_rdy_sel = bus.in_resp_rdy[i];
            end
        end
        id_ok = |resp_hit;
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_resp
        assign bus.in_resp_msg[g] = resp_msg[g];
    end

    assign bus.out_resp_rdy = ~reset & (id_ok ? resp_rdy_sel : 1'b1);
    assign bus.in_resp_val  = (bus.out_resp_val & ~reset) ? resp_hit : '0;
    assign resp_fire        = bus.out_resp_val & bus.out_resp_rdy;
    assign clr_os           = (resp_fire && id_ok) ? resp_hit : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            outstanding <= '0;
            route_err   <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) saved_opq[i] <= '0;
        end else begin
            state       <= state_next;
            rr_ptr      <= ptr_next;
            outstanding <= (outstanding & ~clr_os) | set_os;
            if (accept) saved_opq[win_idx] <= opq_get_id(bus.in_req_msg[win_idx].opaque, IDW);
            if (bus.out_resp_val && !id_ok) route_err <= 1'b1;
        end
    end

endmodule
